// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus of the boot loader.
// The master side is the loader: it consumes the byte stream and drives
// the memory write port. The slave side is the byte source plus memory.
interface program_loader_if #(
  parameter int ADDR_W     = 9,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: takes LEN_HI, LEN_LO, 4*N big-endian data bytes
// and an 8-bit additive checksum, writes each assembled word to program
// memory, and releases the core from reset only after a verified image.
module program_loader #(
  parameter int MEMORY_DEPTH = 512,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpu_reset_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            bidx_q, bidx_d;
  // Only the first three bytes of a word need holding; the fourth arrives
  // on the same cycle the word is committed to the write register.
  logic [DATA_WIDTH-9:0] word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  ready;
  logic                  accept;
  logic [15:0]           len_full;

  assign ready    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept   = ready && bus.byte_valid;
  assign len_full = {len_q[15:8], bus.byte_in};

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          len_d   = '0;
          cnt_d   = '0;
          bidx_d  = '0;
          word_d  = '0;
          csum_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {bus.byte_in, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else if (len_full > 16'(MEMORY_DEPTH)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[DATA_WIDTH-17:0], bus.byte_in};
          csum_d = csum_q + bus.byte_in;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            wdata_d = {word_q, bus.byte_in};
            addr_d  = cnt_q[ADDR_W-1:0];
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_q + 16'd1 == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns to IDLE without touching memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.byte_ready = ready;
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

  assign busy           = ready || (state_q == S_WRITE);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERROR);
  assign cpu_reset_hold = (state_q != S_DONE);

endmodule
